ntt_coef_loader: RTL and testbench

Upstream feeder for the radix-2 polynomial-multiplier core (`top_poly_mul`). It accepts a stream of N coefficients, one per cycle, and reduces each into [0, Q). It scatters them into the two coefficient banks using the conflict-free parity mapping the butterfly engine expects. It then launches the core through `conf` and holds until the core reports completion on `done_flag`. This replaces file preloading of `bank_0`/`bank_1` with a synthesizable load path.

---
 rtl/ntt_pkg.sv | 31 +++
 rtl/ntt_coef_loader_if.sv | 28 ++
 rtl/coef_bank_map.sv | 22 ++
 rtl/ntt_coef_loader.sv | 113 +++++++++++
 tb/tb_ntt_coef_loader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, conf/done codes and types for the NTT coefficient path.
package ntt_pkg;

  localparam int unsigned DATA_WIDTH = 14;
  localparam int unsigned LOGN       = 8;
  localparam int unsigned N          = 1 << LOGN;
  localparam int unsigned ADDR_WIDTH = LOGN - 1;
  localparam int unsigned Q          = 12289;

  localparam logic [2:0] CONF_IDLE = 3'd0;
  localparam logic [2:0] CONF_NTT  = 3'd1;
  localparam logic [2:0] CONF_INTT = 3'd2;
  localparam logic [2:0] CONF_PWM  = 3'd4;

  localparam logic [2:0] DONE_CODE = 3'd1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_WAIT
  } loader_state_e;

  // One bank write: which bank, word address and reduced coefficient.
  typedef struct packed {
    logic                  bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } bank_wr_t;

endpackage

// File: rtl/ntt_coef_loader_if.sv
// Coefficient stream, bank write ports and core control for the loader.
interface ntt_coef_loader_if;
  import ntt_pkg::*;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] waddr0;
  logic [ADDR_WIDTH-1:0] waddr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [2:0]            conf;
  logic [2:0]            done_flag;
  logic                  busy;

  modport master (
    input  in_valid, in_data, done_flag,
    output in_ready, we0, we1, waddr0, waddr1, wdata0, wdata1, conf, busy
  );

  modport slave (
    output in_valid, in_data, done_flag,
    input  in_ready, we0, we1, waddr0, waddr1, wdata0, wdata1, conf, busy
  );

endinterface

// File: rtl/coef_bank_map.sv
// Maps coefficient index and raw value to bank, word address and value mod Q.
module coef_bank_map
  import ntt_pkg::*;
(
  input  logic [LOGN-1:0]       idx,
  input  logic [DATA_WIDTH-1:0] raw,
  output bank_wr_t              wr
);

  localparam logic [DATA_WIDTH:0] QX = (DATA_WIDTH + 1)'(Q);

  logic [DATA_WIDTH:0] diff;

  // Single conditional subtraction; the borrow bit of raw - Q is the compare.
  always_comb begin
    diff    = {1'b0, raw} - QX;
    wr.bank = ^idx;
    wr.addr = idx[LOGN-1:1];
    wr.data = diff[DATA_WIDTH] ? raw : diff[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/ntt_coef_loader.sv
// Streams N coefficients into the two banks, then launches and awaits the NTT core.
module ntt_coef_loader
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ntt_coef_loader_if.master  bus
);

  loader_state_e         state, state_next;
  logic [LOGN-1:0]       cnt;
  logic                  xfer_c;
  bank_wr_t              map_wr;

  logic                  in_ready_q, busy_q;
  logic [2:0]            conf_q;
  logic                  we0_q, we1_q;
  logic [ADDR_WIDTH-1:0] waddr0_q, waddr1_q;
  logic [DATA_WIDTH-1:0] wdata0_q, wdata1_q;

  logic                  in_ready_next, busy_next;
  logic [2:0]            conf_next;

  assign xfer_c = bus.in_valid && in_ready_q;

  coef_bank_map u_map (
    .idx (cnt),
    .raw (bus.in_data),
    .wr  (map_wr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_LOAD;
    else      state <= state_next;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next    = state;
    in_ready_next = 1'b0;
    busy_next     = 1'b1;
    conf_next     = CONF_IDLE;
    case (state)
      ST_LOAD:  if (xfer_c && (cnt == LOGN'(N - 1))) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (bus.done_flag == DONE_CODE) state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
    if (state_next == ST_LOAD) begin
      in_ready_next = 1'b1;
      busy_next     = 1'b0;
    end
    if ((state_next == ST_START) || (state_next == ST_WAIT)) conf_next = CONF_NTT;
  end

  // Registered handshake and core control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      conf_q     <= CONF_IDLE;
    end else begin
      in_ready_q <= in_ready_next;
      busy_q     <= busy_next;
      conf_q     <= conf_next;
    end
  end

  // Coefficient index; wraps to zero on the final beat of a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (xfer_c) cnt <= cnt + LOGN'(1);
  end

  // Registered bank write ports; the idle bank keeps its last address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      we0_q <= 1'b0;
      we1_q <= 1'b0;
      if (xfer_c) begin
        if (map_wr.bank) begin
          we1_q    <= 1'b1;
          waddr1_q <= map_wr.addr;
          wdata1_q <= map_wr.data;
        end else begin
          we0_q    <= 1'b1;
          waddr0_q <= map_wr.addr;
          wdata0_q <= map_wr.data;
        end
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.conf     = conf_q;
  assign bus.we0      = we0_q;
  assign bus.we1      = we1_q;
  assign bus.waddr0   = waddr0_q;
  assign bus.waddr1   = waddr1_q;
  assign bus.wdata0   = wdata0_q;
  assign bus.wdata1   = wdata1_q;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Directed/random bench for ntt_coef_loader with a bank-memory reference model.
module tb_ntt_coef_loader;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_coef_loader_if bus ();

  ntt_coef_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_WIDTH-1:0] stim [N];
  logic [21:0]           wq [$];
  logic [DATA_WIDTH-1:0] mem0 [N/2];
  logic [DATA_WIDTH-1:0] mem1 [N/2];
  int dual_we = 0;
  int late_we = 0;

  // Observe committed writes into a log and a model of the two banks.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.we0 === 1'b1) begin
        wq.push_back({1'b0, bus.waddr0, bus.wdata0});
        mem0[bus.waddr0] = bus.wdata0;
      end
      if (bus.we1 === 1'b1) begin
        wq.push_back({1'b1, bus.waddr1, bus.wdata1});
        mem1[bus.waddr1] = bus.wdata1;
      end
      if (bus.we0 === 1'b1 && bus.we1 === 1'b1) dual_we++;
      if ((bus.we0 === 1'b1 || bus.we1 === 1'b1) && bus.conf !== 3'd0) late_we++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] reduce(input logic [DATA_WIDTH-1:0] v);
    return DATA_WIDTH'(32'(v) % Q);
  endfunction

  // Expected log entry for coefficient index i.
  function automatic logic [21:0] expect_wr(input int i);
    logic [7:0] ib;
    ib = 8'(i);
    return {^ib, ib[7:1], reduce(stim[i])};
  endfunction

  task automatic run_load(input bit gaps);
    int not_ready;
    int k;
    int errs;
    int n1;
    logic [7:0] ib;
    not_ready = 0;
    wq.delete();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        k = 0;
        while (k < 6 && $urandom_range(0, 1) == 1) begin
          bus.in_valid = 1'b0;
          bus.in_data  = DATA_WIDTH'($urandom);
          @(posedge clk); #1;
          k++;
        end
      end
      if (bus.in_ready !== 1'b1) not_ready++;
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      @(posedge clk); #1;
    end
    // Keep offering junk while not ready; it must never be consumed.
    bus.in_data = DATA_WIDTH'($urandom);
    check("ready_during_load", not_ready, 0);
    @(negedge clk);
    check("flush_ready", bus.in_ready, 0);
    check("flush_conf", bus.conf, 0);
    check("flush_busy", bus.busy, 1);
    @(negedge clk);
    check("launch_conf", bus.conf, CONF_NTT);
    check("launch_busy", bus.busy, 1);
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check("write_count", wq.size(), N);
    errs = 0;
    n1   = 0;
    for (int i = 0; i < N && i < wq.size(); i++) begin
      if (wq[i] !== expect_wr(i)) errs++;
      if (wq[i][21] === 1'b1) n1++;
    end
    check("write_sequence", errs, 0);
    check("bank1_writes", n1, N / 2);
    check("bank0_writes", wq.size() - n1, N / 2);
    errs = 0;
    for (int i = 0; i < N; i++) begin
      ib = 8'(i);
      if (^ib) begin
        if (mem1[ib[7:1]] !== reduce(stim[i])) errs++;
      end else begin
        if (mem0[ib[7:1]] !== reduce(stim[i])) errs++;
      end
    end
    check("bank_contents", errs, 0);
  endtask

  // Drive done from the negedge; checks land before and after the sampling edge.
  task automatic finish_ntt(input bit with_other);
    if (with_other) begin
      bus.done_flag = 3'd2;
      repeat (3) @(negedge clk);
      check("wait_conf", bus.conf, CONF_NTT);
      check("wait_ready", bus.in_ready, 0);
      check("wait_busy", bus.busy, 1);
    end
    bus.done_flag = DONE_CODE;
    check("pre_done_conf", bus.conf, CONF_NTT);
    @(negedge clk);
    check("done_conf", bus.conf, 0);
    check("done_ready", bus.in_ready, 1);
    check("done_busy", bus.busy, 0);
    bus.done_flag = 3'd0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.done_flag = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.in_ready, 1);
    check("rst_we0", bus.we0, 0);
    check("rst_we1", bus.we1, 0);
    check("rst_waddr0", bus.waddr0, 0);
    check("rst_waddr1", bus.waddr1, 0);
    check("rst_wdata0", bus.wdata0, 0);
    check("rst_wdata1", bus.wdata1, 0);
    check("rst_conf", bus.conf, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;

    // Ordered load, no bubbles.
    for (int i = 0; i < N; i++) stim[i] = DATA_WIDTH'(i);
    run_load(1'b0);
    check("first_wr0", wq[0], {1'b0, 7'd0, 14'd0});
    check("first_wr1", wq[1], {1'b1, 7'd0, 14'd1});
    check("first_wr2", wq[2], {1'b1, 7'd1, 14'd2});
    check("first_wr3", wq[3], {1'b0, 7'd1, 14'd3});
    finish_ntt(1'b1);

    // Stale done while loading has no effect.
    bus.done_flag = DONE_CODE;
    repeat (3) @(negedge clk);
    check("stale_done_ready", bus.in_ready, 1);
    check("stale_done_busy", bus.busy, 0);
    check("stale_done_conf", bus.conf, 0);
    bus.done_flag = 3'd0;

    // Random data with reduction corners, gappy valid.
    for (int i = 0; i < N; i++) stim[i] = DATA_WIDTH'($urandom);
    stim[0] = 14'd12288;
    stim[1] = 14'd12289;
    stim[2] = 14'd16383;
    run_load(1'b1);
    check("reduce_12288", mem0[0], 12288);
    check("reduce_12289", mem1[0], 0);
    check("reduce_16383", mem1[1], 4094);
    finish_ntt(1'b0);

    // Load, then reset while waiting on the core.
    for (int i = 0; i < N; i++) stim[i] = DATA_WIDTH'($urandom);
    run_load(1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_conf", bus.conf, 0);
    check("midrst_we0", bus.we0, 0);
    check("midrst_we1", bus.we1, 0);
    check("midrst_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < N; i++) stim[i] = DATA_WIDTH'($urandom);
    run_load(1'b1);
    finish_ntt(1'b1);

    check("dual_bank_writes", dual_we, 0);
    check("writes_after_launch", late_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
